// File: rtl/rv32i_defines.sv
// Shared types and encodings for the multicycle RV32I controller: FSM states,
// datapath mux selects, ALU operations, opcodes and branch funct3 values.
package rv32i_defines;

    typedef enum logic [3:0] {
        S_FETCH    = 4'h0,
        S_DECODE   = 4'h1,
        S_MEMADR   = 4'h2,
        S_MEMREAD  = 4'h3,
        S_MEMWB    = 4'h4,
        S_MEMWRITE = 4'h5,
        S_EXECUTER = 4'h6,
        S_EXECUTEI = 4'h7,
        S_ALUWB    = 4'h8,
        S_JAL      = 4'h9,
        S_JALR     = 4'hA,
        S_BRANCH   = 4'hB,
        S_LUI      = 4'hC,
        S_ERROR    = 4'hF
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'd0,
        ALU_SUB    = 2'd1,
        ALU_FUNCT  = 2'd2,
        ALU_PASS_B = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_A_PC     = 2'd0,
        SRC_A_PC_OLD = 2'd1,
        SRC_A_RS1    = 2'd2
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'd0,
        SRC_B_IMM  = 2'd1,
        SRC_B_FOUR = 2'd2
    } alu_src_b_t;

    typedef enum logic [1:0] {
        RES_ALU      = 2'd0,
        RES_MEM_DATA = 2'd1,
        RES_ALU_LAST = 2'd2
    } result_src_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // States that hold a memory request open until mem_ready
    function automatic logic is_wait_state(input ctrl_state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/rv32i_branch_cond.sv
// Branch resolution: maps the branch funct3 and the ALU compare flags to taken.
module rv32i_branch_cond
    import rv32i_defines::*;
(
    input  logic [2:0] funct3,
    input  logic       equal,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = equal;
            F3_BNE:  taken = !equal;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = !lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32i_multicycle_controller.sv
// Main control FSM of the multicycle RV32I core with mem_req/mem_ready handshake and wait timeout.
// Define RV32I_CTRL_ILLEGAL_TRAP_EN to send unrecognised opcodes to S_ERROR instead of retiring them as NOPs.
module rv32i_multicycle_controller
    import rv32i_defines::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             mem_ready,
    input  logic             equal,
    input  logic             lt,
    input  logic             ltu,
    output logic             mem_req,
    output logic             mem_wr_ena,
    output logic             mem_src,
    output logic             ir_write,
    output logic             pc_ena,
    output logic             reg_write,
    output logic             alu_ena,
    output logic             mem_data_ena,
    output alu_src_a_t       alu_src_a,
    output alu_src_b_t       alu_src_b,
    output alu_op_t          alu_op,
    output result_src_t      result_src,
    output logic [CNT_W-1:0] instructions_completed,
    output logic [3:0]       state_dbg,
    output logic             error
);

    ctrl_state_t      state;
    ctrl_state_t      next_state;
    logic [TMO_W-1:0] wait_cnt;
    logic             taken;
    logic             waiting;
    logic             timed_out;

    rv32i_branch_cond u_branch_cond (
        .funct3 (funct3),
        .equal  (equal),
        .lt     (lt),
        .ltu    (ltu),
        .taken  (taken)
    );

    // A completing access (mem_ready=1) always wins over the timeout
    assign waiting   = is_wait_state(state) && !mem_ready;
    assign timed_out = (TIMEOUT != 0) && waiting && (wait_cnt == TMO_W'(TIMEOUT));
    assign state_dbg = state;

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (timed_out)      next_state = S_ERROR;
                else if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_R:              next_state = S_EXECUTER;
                    OP_I:              next_state = S_EXECUTEI;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_ALUWB;
`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
                    default:           next_state = S_ERROR;
`else
                    default:           next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (timed_out)      next_state = S_ERROR;
                else if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: begin
                if (timed_out)      next_state = S_ERROR;
                else if (mem_ready) next_state = S_FETCH;
            end
            S_EXECUTER: next_state = S_ALUWB;
            S_EXECUTEI: next_state = S_ALUWB;
            S_LUI:      next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_JALR:     next_state = S_JAL;
            S_JAL:      next_state = S_ALUWB;
            S_BRANCH:   next_state = S_FETCH;
            S_ERROR:    next_state = S_ERROR;
            default:    next_state = S_ERROR;
        endcase
    end

    // Every return to S_FETCH from another state is a retired instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                  <= S_FETCH;
            wait_cnt               <= '0;
            instructions_completed <= '0;
            error                  <= 1'b0;
        end else if (ena) begin
            state <= next_state;
            error <= (next_state == S_ERROR);
            if (next_state != state)
                wait_cnt <= '0;
            else if (waiting && (wait_cnt != '1))
                wait_cnt <= wait_cnt + 1'b1;
            if ((next_state == S_FETCH) && (state != S_FETCH))
                instructions_completed <= instructions_completed + 1'b1;
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_wr_ena   = 1'b0;
        mem_src      = 1'b0;
        ir_write     = 1'b0;
        pc_ena       = 1'b0;
        reg_write    = 1'b0;
        alu_ena      = 1'b0;
        mem_data_ena = 1'b0;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_RS2;
        alu_op       = ALU_ADD;
        result_src   = RES_ALU;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_ena    = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_PC_OLD;
                alu_src_b = SRC_B_IMM;
                alu_ena   = 1'b1;
            end
            S_MEMADR, S_JALR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_ena   = 1'b1;
            end
            S_MEMREAD: begin
                mem_req      = 1'b1;
                mem_src      = 1'b1;
                mem_data_ena = mem_ready;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                result_src = RES_MEM_DATA;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                mem_wr_ena = 1'b1;
                mem_src    = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_FUNCT;
                alu_ena   = 1'b1;
            end
            S_EXECUTEI: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_FUNCT;
                alu_ena   = 1'b1;
            end
            S_LUI: begin
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_PASS_B;
                alu_ena   = 1'b1;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                result_src = RES_ALU_LAST;
            end
            // PC takes the jump target while the ALU forms the link address PC_old+4
            S_JAL: begin
                pc_ena     = 1'b1;
                result_src = RES_ALU_LAST;
                alu_src_a  = SRC_A_PC_OLD;
                alu_src_b  = SRC_B_FOUR;
                alu_ena    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_op     = ALU_SUB;
                pc_ena     = taken;
                result_src = RES_ALU_LAST;
            end
            default: begin
            end
        endcase
        if (!ena) begin
            mem_req      = 1'b0;
            mem_wr_ena   = 1'b0;
            ir_write     = 1'b0;
            pc_ena       = 1'b0;
            reg_write    = 1'b0;
            alu_ena      = 1'b0;
            mem_data_ena = 1'b0;
        end
    end

endmodule

// File: tb/tb_rv32i_multicycle_controller.sv
// Directed, table-driven bench for rv32i_multicycle_controller with hand sequences
// for illegal opcodes, memory timeout and asynchronous reset mid-access.
`timescale 1ns/1ps
module tb_rv32i_multicycle_controller;
    import rv32i_defines::*;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 4;
    localparam int TMO_W   = 8;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JLR = 7'b1100111;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] LU  = 7'b0110111;
    localparam logic [6:0] AU  = 7'b0010111;

    // Enable vector bit order: mem_req, mem_wr_ena, ir_write, pc_ena, reg_write, alu_ena, mem_data_ena
    localparam logic [6:0] E_FETCH = 7'b1011000;
    localparam logic [6:0] E_WAIT  = 7'b1000000;
    localparam logic [6:0] E_ALU   = 7'b0000010;
    localparam logic [6:0] E_WB    = 7'b0000100;
    localparam logic [6:0] E_PC    = 7'b0001000;
    localparam logic [6:0] E_RD    = 7'b1000001;
    localparam logic [6:0] E_WR    = 7'b1100000;
    localparam logic [6:0] E_JAL   = 7'b0001010;
    localparam logic [6:0] E_NONE  = 7'b0000000;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             mem_ready;
    logic             equal;
    logic             lt;
    logic             ltu;
    logic             mem_req;
    logic             mem_wr_ena;
    logic             mem_src;
    logic             ir_write;
    logic             pc_ena;
    logic             reg_write;
    logic             alu_ena;
    logic             mem_data_ena;
    alu_src_a_t       alu_src_a;
    alu_src_b_t       alu_src_b;
    alu_op_t          alu_op;
    result_src_t      result_src;
    logic [CNT_W-1:0] instructions_completed;
    logic [3:0]       state_dbg;
    logic             error;
    logic [6:0]       en_vec;

    rv32i_multicycle_controller #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .TMO_W   (TMO_W)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .ena                    (ena),
        .op                     (op),
        .funct3                 (funct3),
        .mem_ready              (mem_ready),
        .equal                  (equal),
        .lt                     (lt),
        .ltu                    (ltu),
        .mem_req                (mem_req),
        .mem_wr_ena             (mem_wr_ena),
        .mem_src                (mem_src),
        .ir_write               (ir_write),
        .pc_ena                 (pc_ena),
        .reg_write              (reg_write),
        .alu_ena                (alu_ena),
        .mem_data_ena           (mem_data_ena),
        .alu_src_a              (alu_src_a),
        .alu_src_b              (alu_src_b),
        .alu_op                 (alu_op),
        .result_src             (result_src),
        .instructions_completed (instructions_completed),
        .state_dbg              (state_dbg),
        .error                  (error)
    );

    always #5 clk = ~clk;

    assign en_vec = {mem_req, mem_wr_ena, ir_write, pc_ena, reg_write, alu_ena, mem_data_ena};

    typedef struct {
        logic        ena;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        rdy;
        logic [2:0]  flags;
        ctrl_state_t st;
        logic [6:0]  en;
        logic        msrc;
        result_src_t rsrc;
        alu_op_t     aop;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   testsRun    = 0;
    int   testsFailed = 0;

    task automatic addRow(input logic e, input logic [6:0] o, input logic [2:0] f, input logic r,
                          input logic [2:0] fl, input ctrl_state_t s, input logic [6:0] en,
                          input logic ms, input result_src_t rs, input alu_op_t ao, input logic [31:0] c);
        vec_t v;
        v = '{e, o, f, r, fl, s, en, ms, rs, ao, c};
        tbl.push_back(v);
    endtask

    task automatic compareValue(input string name, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        ena       = v.ena;
        op        = v.op;
        funct3    = v.f3;
        mem_ready = v.rdy;
        {equal, lt, ltu} = v.flags;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        compareValue($sformatf("row%0d state", idx), {28'd0, state_dbg}, {28'd0, v.st});
        compareValue($sformatf("row%0d enables", idx), {25'd0, en_vec}, {25'd0, v.en});
        compareValue($sformatf("row%0d mem_src", idx), {31'd0, mem_src}, {31'd0, v.msrc});
        compareValue($sformatf("row%0d result_src", idx), {30'd0, result_src}, {30'd0, v.rsrc});
        compareValue($sformatf("row%0d alu_op", idx), {30'd0, alu_op}, {30'd0, v.aop});
        compareValue($sformatf("row%0d count", idx), instructions_completed, v.cnt);
        compareValue($sformatf("row%0d error", idx), {31'd0, error}, 32'd0);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]  expState;
        logic [31:0] expCount;
        logic        expError;

        rst = 1'b1; ena = 1'b1; op = '0; funct3 = '0; mem_ready = 1'b0;
        equal = 1'b0; lt = 1'b0; ltu = 1'b0;

        // addi x1,x0,5
        addRow(1, IT, 3'd0, 1, 3'b000, S_FETCH,    E_FETCH, 0, RES_ALU,      ALU_ADD,    0);
        addRow(1, IT, 3'd0, 1, 3'b000, S_DECODE,   E_ALU,   0, RES_ALU,      ALU_ADD,    0);
        addRow(1, IT, 3'd0, 1, 3'b000, S_EXECUTEI, E_ALU,   0, RES_ALU,      ALU_FUNCT,  0);
        addRow(1, IT, 3'd0, 1, 3'b000, S_ALUWB,    E_WB,    0, RES_ALU_LAST, ALU_ADD,    0);
        // lw with three wait cycles in MEMREAD
        addRow(1, LW, 3'd2, 1, 3'b000, S_FETCH,    E_FETCH, 0, RES_ALU,      ALU_ADD,    1);
        addRow(1, LW, 3'd2, 1, 3'b000, S_DECODE,   E_ALU,   0, RES_ALU,      ALU_ADD,    1);
        addRow(1, LW, 3'd2, 1, 3'b000, S_MEMADR,   E_ALU,   0, RES_ALU,      ALU_ADD,    1);
        addRow(1, LW, 3'd2, 0, 3'b000, S_MEMREAD,  E_WAIT,  1, RES_ALU,      ALU_ADD,    1);
        addRow(1, LW, 3'd2, 0, 3'b000, S_MEMREAD,  E_WAIT,  1, RES_ALU,      ALU_ADD,    1);
        addRow(1, LW, 3'd2, 0, 3'b000, S_MEMREAD,  E_WAIT,  1, RES_ALU,      ALU_ADD,    1);
        addRow(1, LW, 3'd2, 1, 3'b000, S_MEMREAD,  E_RD,    1, RES_ALU,      ALU_ADD,    1);
        addRow(1, LW, 3'd2, 1, 3'b000, S_MEMWB,    E_WB,    0, RES_MEM_DATA, ALU_ADD,    1);
        // bge taken (lt=0), then not taken (lt=1)
        addRow(1, BR, 3'd5, 1, 3'b000, S_FETCH,    E_FETCH, 0, RES_ALU,      ALU_ADD,    2);
        addRow(1, BR, 3'd5, 1, 3'b000, S_DECODE,   E_ALU,   0, RES_ALU,      ALU_ADD,    2);
        addRow(1, BR, 3'd5, 1, 3'b000, S_BRANCH,   E_PC,    0, RES_ALU_LAST, ALU_SUB,    2);
        addRow(1, BR, 3'd5, 1, 3'b010, S_FETCH,    E_FETCH, 0, RES_ALU,      ALU_ADD,    3);
        addRow(1, BR, 3'd5, 1, 3'b010, S_DECODE,   E_ALU,   0, RES_ALU,      ALU_ADD,    3);
        addRow(1, BR, 3'd5, 1, 3'b010, S_BRANCH,   E_NONE,  0, RES_ALU_LAST, ALU_SUB,    3);
        // jalr: JALR -> JAL -> ALUWB
        addRow(1, JLR, 3'd0, 1, 3'b000, S_FETCH,   E_FETCH, 0, RES_ALU,      ALU_ADD,    4);
        addRow(1, JLR, 3'd0, 1, 3'b000, S_DECODE,  E_ALU,   0, RES_ALU,      ALU_ADD,    4);
        addRow(1, JLR, 3'd0, 1, 3'b000, S_JALR,    E_ALU,   0, RES_ALU,      ALU_ADD,    4);
        addRow(1, JLR, 3'd0, 1, 3'b000, S_JAL,     E_JAL,   0, RES_ALU_LAST, ALU_ADD,    4);
        addRow(1, JLR, 3'd0, 1, 3'b000, S_ALUWB,   E_WB,    0, RES_ALU_LAST, ALU_ADD,    4);
        // sw with a three-cycle stall in MEMWRITE; mem_ready during the stall must be ignored
        addRow(1, SW, 3'd2, 1, 3'b000, S_FETCH,    E_FETCH, 0, RES_ALU,      ALU_ADD,    5);
        addRow(1, SW, 3'd2, 1, 3'b000, S_DECODE,   E_ALU,   0, RES_ALU,      ALU_ADD,    5);
        addRow(1, SW, 3'd2, 1, 3'b000, S_MEMADR,   E_ALU,   0, RES_ALU,      ALU_ADD,    5);
        addRow(1, SW, 3'd2, 0, 3'b000, S_MEMWRITE, E_WR,    1, RES_ALU,      ALU_ADD,    5);
        addRow(0, SW, 3'd2, 1, 3'b000, S_MEMWRITE, E_NONE,  1, RES_ALU,      ALU_ADD,    5);
        addRow(0, SW, 3'd2, 1, 3'b000, S_MEMWRITE, E_NONE,  1, RES_ALU,      ALU_ADD,    5);
        addRow(0, SW, 3'd2, 1, 3'b000, S_MEMWRITE, E_NONE,  1, RES_ALU,      ALU_ADD,    5);
        addRow(1, SW, 3'd2, 1, 3'b000, S_MEMWRITE, E_WR,    1, RES_ALU,      ALU_ADD,    5);
        // lui
        addRow(1, LU, 3'd0, 1, 3'b000, S_FETCH,    E_FETCH, 0, RES_ALU,      ALU_ADD,    6);
        addRow(1, LU, 3'd0, 1, 3'b000, S_DECODE,   E_ALU,   0, RES_ALU,      ALU_ADD,    6);
        addRow(1, LU, 3'd0, 1, 3'b000, S_LUI,      E_ALU,   0, RES_ALU,      ALU_PASS_B, 6);
        addRow(1, LU, 3'd0, 1, 3'b000, S_ALUWB,    E_WB,    0, RES_ALU_LAST, ALU_ADD,    6);
        // R-type add
        addRow(1, RT, 3'd0, 1, 3'b000, S_FETCH,    E_FETCH, 0, RES_ALU,      ALU_ADD,    7);
        addRow(1, RT, 3'd0, 1, 3'b000, S_DECODE,   E_ALU,   0, RES_ALU,      ALU_ADD,    7);
        addRow(1, RT, 3'd0, 1, 3'b000, S_EXECUTER, E_ALU,   0, RES_ALU,      ALU_FUNCT,  7);
        addRow(1, RT, 3'd0, 1, 3'b000, S_ALUWB,    E_WB,    0, RES_ALU_LAST, ALU_ADD,    7);
        // remaining branch kinds: beq taken, bne not, bltu taken, bgeu not, blt taken
        addRow(1, BR, 3'd0, 1, 3'b100, S_FETCH,    E_FETCH, 0, RES_ALU,      ALU_ADD,    8);
        addRow(1, BR, 3'd0, 1, 3'b100, S_DECODE,   E_ALU,   0, RES_ALU,      ALU_ADD,    8);
        addRow(1, BR, 3'd0, 1, 3'b100, S_BRANCH,   E_PC,    0, RES_ALU_LAST, ALU_SUB,    8);
        addRow(1, BR, 3'd1, 1, 3'b100, S_FETCH,    E_FETCH, 0, RES_ALU,      ALU_ADD,    9);
        addRow(1, BR, 3'd1, 1, 3'b100, S_DECODE,   E_ALU,   0, RES_ALU,      ALU_ADD,    9);
        addRow(1, BR, 3'd1, 1, 3'b100, S_BRANCH,   E_NONE,  0, RES_ALU_LAST, ALU_SUB,    9);
        addRow(1, BR, 3'd6, 1, 3'b001, S_FETCH,    E_FETCH, 0, RES_ALU,      ALU_ADD,    10);
        addRow(1, BR, 3'd6, 1, 3'b001, S_DECODE,   E_ALU,   0, RES_ALU,      ALU_ADD,    10);
        addRow(1, BR, 3'd6, 1, 3'b001, S_BRANCH,   E_PC,    0, RES_ALU_LAST, ALU_SUB,    10);
        addRow(1, BR, 3'd7, 1, 3'b001, S_FETCH,    E_FETCH, 0, RES_ALU,      ALU_ADD,    11);
        addRow(1, BR, 3'd7, 1, 3'b001, S_DECODE,   E_ALU,   0, RES_ALU,      ALU_ADD,    11);
        addRow(1, BR, 3'd7, 1, 3'b001, S_BRANCH,   E_NONE,  0, RES_ALU_LAST, ALU_SUB,    11);
        addRow(1, BR, 3'd4, 1, 3'b010, S_FETCH,    E_FETCH, 0, RES_ALU,      ALU_ADD,    12);
        addRow(1, BR, 3'd4, 1, 3'b010, S_DECODE,   E_ALU,   0, RES_ALU,      ALU_ADD,    12);
        addRow(1, BR, 3'd4, 1, 3'b010, S_BRANCH,   E_PC,    0, RES_ALU_LAST, ALU_SUB,    12);
        // auipc goes straight from DECODE to ALUWB
        addRow(1, AU, 3'd0, 1, 3'b000, S_FETCH,    E_FETCH, 0, RES_ALU,      ALU_ADD,    13);
        addRow(1, AU, 3'd0, 1, 3'b000, S_DECODE,   E_ALU,   0, RES_ALU,      ALU_ADD,    13);
        addRow(1, AU, 3'd0, 1, 3'b000, S_ALUWB,    E_WB,    0, RES_ALU_LAST, ALU_ADD,    13);
        addRow(1, AU, 3'd0, 0, 3'b000, S_FETCH,    E_WAIT,  0, RES_ALU,      ALU_ADD,    14);

        // Reset state while rst is held
        repeat (2) @(negedge clk);
        #2;
        compareValue("reset state", {28'd0, state_dbg}, {28'd0, S_FETCH});
        compareValue("reset enables", {25'd0, en_vec}, {25'd0, E_WAIT});
        compareValue("reset mem_src", {31'd0, mem_src}, 32'd0);
        compareValue("reset count", instructions_completed, 32'd0);
        compareValue("reset error", {31'd0, error}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            #2;
            checkOutput(tbl[i], i);
            @(negedge clk);
        end

        // Unrecognised opcode: trap or NOP depending on configuration
        ena = 1'b1; op = 7'h7F; funct3 = 3'd0; mem_ready = 1'b1;
        {equal, lt, ltu} = 3'b000;
        pulseReset();
        compareValue("illegal reset count", instructions_completed, 32'd0);
        @(negedge clk);
        compareValue("illegal decode state", {28'd0, state_dbg}, {28'd0, S_DECODE});
        @(negedge clk);
`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
        expState = S_ERROR; expCount = 32'd0; expError = 1'b1;
`else
        expState = S_FETCH; expCount = 32'd1; expError = 1'b0;
`endif
        compareValue("illegal next state", {28'd0, state_dbg}, {28'd0, expState});
        compareValue("illegal count", instructions_completed, expCount);
        compareValue("illegal error", {31'd0, error}, {31'd0, expError});

        // Fetch timeout with TIMEOUT=4: error after the fifth stalled cycle, sticky until rst
        mem_ready = 1'b0; op = IT;
        pulseReset();
        repeat (4) @(negedge clk);
        compareValue("timeout still fetch", {28'd0, state_dbg}, {28'd0, S_FETCH});
        compareValue("timeout error early", {31'd0, error}, 32'd0);
        @(negedge clk);
        compareValue("timeout error state", {28'd0, state_dbg}, {28'd0, S_ERROR});
        compareValue("timeout error set", {31'd0, error}, 32'd1);
        compareValue("timeout enables off", {25'd0, en_vec}, 32'd0);
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        compareValue("timeout error sticky", {31'd0, error}, 32'd1);
        compareValue("timeout state sticky", {28'd0, state_dbg}, {28'd0, S_ERROR});
        #2;
        rst = 1'b1;
        #1;
        compareValue("timeout rst state", {28'd0, state_dbg}, {28'd0, S_FETCH});
        compareValue("timeout rst error", {31'd0, error}, 32'd0);
        compareValue("timeout rst count", instructions_completed, 32'd0);
        rst = 1'b0;

        // Asynchronous reset abandons an outstanding load
        @(negedge clk);
        op = LW; mem_ready = 1'b1;
        pulseReset();
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        compareValue("abort in memread", {28'd0, state_dbg}, {28'd0, S_MEMREAD});
        compareValue("abort mem_src", {31'd0, mem_src}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        compareValue("abort rst state", {28'd0, state_dbg}, {28'd0, S_FETCH});
        compareValue("abort rst enables", {25'd0, en_vec}, {25'd0, E_WAIT});
        compareValue("abort rst mem_src", {31'd0, mem_src}, 32'd0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
